arb_root_responder: RTL and testbench
=====================================

# arb_root_responder

Synchronous resource-side responder that closes the four-phase request/acknowledge handshake at the root of the two-input arbiter tree. It takes the tree's root request (asynchronous to this clock), synchronises it, runs a fixed-length service window on the shared resource, and then raises the root acknowledge. It holds the acknowledge until the request is withdrawn, which lets the tree release the winning leaf. It also counts grants and flags protocol violations.

## Interface
- SYNC_STAGES, 2, synchroniser flops on `req_i`; must be ≥2.
- SERVICE_CYCLES, 4, cycles spent in SERVE before acknowledge; must be ≥1.
- CNT_W, 16, width of `grant_count_o`.
- TIMEOUT_CYCLES, 64, maximum cycles ACK may be held. Used only with ARB_RESP_TIMEOUT_EN; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_i  in  1  root request from the arbiter tree; asynchronous, four-phase.
- ack_o  out  1  root acknowledge to the tree; registered.
- busy_o  out  1  high in SERVE and ACK.
- svc_start_o  out  1  one-cycle pulse on entry to SERVE.
- grant_count_o  out  CNT_W  number of completed grants; saturates at all-ones.
- clr_i  in  1  synchronous clear of `grant_count_o`, `protocol_err_o` and `timeout_o`.
- protocol_err_o  out  1  sticky; set when the request is withdrawn before acknowledge.
- timeout_o  out  1  sticky; set when ACK is held longer than allowed (requires ARB_RESP_TIMEOUT_EN).

## Operation
- `req_s` is `req_i` after SYNC_STAGES flops. All FSM decisions use `req_s` only.
- States: IDLE, SERVE, ACK, LOCKOUT.
- IDLE:
  - `req_s`=1 → SERVE, service counter loaded with SERVICE_CYCLES-1, `svc_start_o`=1 for that cycle.
- SERVE:
  - `req_s`=0 → IDLE and set `protocol_err_o`; `ack_o` is never raised for this request.
  - Otherwise, counter==0 → ACK with `ack_o`=1, and `grant_count_o` +1 (saturating).
  - Otherwise, counter −1.
- ACK:
  - `req_s`=0 → IDLE with `ack_o`=0.
  - Timeout expiry (macro only) → LOCKOUT with `ack_o`=0 and `timeout_o`=1.
- LOCKOUT:
  - `req_s`=0 → IDLE. A held request is never re-granted.
- `clr_i` takes priority over same-cycle increment or set. It does not affect FSM state, `ack_o` or the synchroniser.
- Reset values: state=IDLE, `ack_o`=0, `busy_o`=0, `svc_start_o`=0, `grant_count_o`=0, `protocol_err_o`=0, `timeout_o`=0, all synchroniser flops=0.
- Reset mid-operation: `ack_o` drops immediately (asynchronously). A request still high after reset release is served as a fresh request.

## Timing
- Let E1 be the first edge that samples `req_i`=1.
  - `req_s` rises after edge E(SYNC_STAGES).
  - SERVE is entered at edge E(SYNC_STAGES+1).
  - `ack_o` rises at edge E(SYNC_STAGES+1+SERVICE_CYCLES). With defaults, `ack_o` rises at E7.
- Release: if the first edge sampling `req_i`=0 is F1, `ack_o` falls at edge F(SYNC_STAGES+1). With defaults, `ack_o` falls at F3.
- Back-to-back: a new rise of `req_i` after `ack_o` falls restarts the full latency. There is no bubble beyond synchronisation.
- Pulses on `req_i` shorter than one clock period are not guaranteed to be seen.
- Timeout: `ack_o` falls at the end of cycle TIMEOUT_CYCLES counted from the ACK-entry edge, if `req_s` stays 1 throughout.

## Configuration
- ARB_RESP_TIMEOUT_EN defined:
  - ACK-hold watchdog present: counter, LOCKOUT state, live `timeout_o`.
- Undefined:
  - ACK waits indefinitely for `req_s`=0.
  - LOCKOUT is unreachable.
  - `timeout_o` is tied 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Reset, then `req_i` high at edge 1, defaults → `svc_start_o` pulse after E3, `ack_o` 1 at E7, `grant_count_o`=1. Drop `req_i` → `ack_o` 0 two edges after the first sampled 0.
- Three back-to-back full handshakes → three `svc_start_o` pulses, `grant_count_o`=3, `protocol_err_o`=0.
- `req_i` dropped during SERVE (2 cycles in) → `ack_o` never rises, `protocol_err_o`=1, state IDLE. Then pulse `clr_i` → `protocol_err_o`=0.
- With macro, TIMEOUT_CYCLES=8, `req_i` held high → `ack_o` falls 8 cycles after rising, `timeout_o`=1, no re-grant until `req_i` goes low and high again.
- CNT_W=2: five grants → `grant_count_o` saturates at 3.
- `rst_n` asserted while `ack_o`=1 → `ack_o`=0 without a clock edge. Release with `req_i` still high → re-served with full latency, count restarts from 0.

Source files
------------

// File: rtl/arb_root_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_root_responder_if
// Description : Root handshake and status bundle between the arbiter tree
//               (master side) and the resource responder (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_root_responder_if #(
    parameter int CNT_W = 16
) ();
    logic             req_i;
    logic             ack_o;
    logic             busy_o;
    logic             svc_start_o;
    logic [CNT_W-1:0] grant_count_o;
    logic             clr_i;
    logic             protocol_err_o;
    logic             timeout_o;

    // Responder side
    modport slave (
        input  req_i,
        input  clr_i,
        output ack_o,
        output busy_o,
        output svc_start_o,
        output grant_count_o,
        output protocol_err_o,
        output timeout_o
    );

    // Arbiter-tree / requester side
    modport master (
        output req_i,
        output clr_i,
        input  ack_o,
        input  busy_o,
        input  svc_start_o,
        input  grant_count_o,
        input  protocol_err_o,
        input  timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/arb_root_responder.sv
`default_nettype none
// ============================================================================
// Module      : arb_root_responder
// Description : Resource-side responder closing the four-phase req/ack
//               handshake at the root of the arbiter tree. Synchronises the
//               asynchronous request, runs a fixed service window, raises
//               ack until the request drops, counts grants and flags
//               protocol violations.
//               Optional ACK-hold watchdog: define ARB_RESP_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_root_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int SERVICE_CYCLES = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    arb_root_responder_if.slave  bus
);

    localparam int c_SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
    localparam logic [c_SVC_W-1:0] c_SVC_LOAD = c_SVC_W'(SERVICE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SERVE   = 2'd1;
    localparam logic [1:0] c_ST_ACK     = 2'd2;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd3;

    // Reject illegal configurations at elaboration time
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (SERVICE_CYCLES < 1) begin : g_chk_svc
        $error("SERVICE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_to
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_SVC_W-1:0]     r_svc_cnt;
    logic                   r_ack;
    logic                   r_busy;
    logic                   r_svc_start;
    logic [CNT_W-1:0]       r_grant_count;
    logic                   r_protocol_err;
    logic                   r_timeout;
    logic                   w_to_expired;
    logic                   w_ack_nxt;
    logic                   w_busy_nxt;
    logic                   w_svc_start_nxt;
    logic                   w_grant_inc;
    logic                   w_err_set;
    logic                   w_timeout_set;

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Request synchroniser: shift req_i through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_i};
        end
    end

    // Service-window counter: parked at the load value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_svc_cnt <= c_SVC_LOAD;
        end else if (r_state == c_ST_IDLE) begin
            r_svc_cnt <= c_SVC_LOAD;
        end else if (r_state == c_ST_SERVE && r_svc_cnt != '0) begin
            r_svc_cnt <= r_svc_cnt - 1'b1;
        end
    end

`ifdef ARB_RESP_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LOAD = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // ACK-hold watchdog: armed during SERVE, counts down while in ACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= c_TO_LOAD;
        end else if (r_state == c_ST_SERVE) begin
            r_to_cnt <= c_TO_LOAD;
        end else if (r_state == c_ST_ACK && r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_to_expired = (r_to_cnt == '0);
`else
    assign w_to_expired = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; request withdrawal always wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_s) w_state_nxt = c_ST_SERVE;
            end
            c_ST_SERVE: begin
                if (!w_req_s)              w_state_nxt = c_ST_IDLE;
                else if (r_svc_cnt == '0)  w_state_nxt = c_ST_ACK;
            end
            c_ST_ACK: begin
                if (!w_req_s)          w_state_nxt = c_ST_IDLE;
                else if (w_to_expired) w_state_nxt = c_ST_LOCKOUT;
            end
            c_ST_LOCKOUT: begin
                if (!w_req_s) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM output decode, registered below so every output is flop-driven
    always_comb begin
        w_ack_nxt       = (w_state_nxt == c_ST_ACK);
        w_busy_nxt      = (w_state_nxt == c_ST_SERVE) || (w_state_nxt == c_ST_ACK);
        w_svc_start_nxt = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_SERVE);
        w_grant_inc     = (r_state == c_ST_SERVE) && (w_state_nxt == c_ST_ACK);
        w_err_set       = (r_state == c_ST_SERVE) && !w_req_s;
        w_timeout_set   = (r_state == c_ST_ACK) && (w_state_nxt == c_ST_LOCKOUT);
    end

    // Handshake outputs; async reset drops ack immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_svc_start <= 1'b0;
        end else begin
            r_ack       <= w_ack_nxt;
            r_busy      <= w_busy_nxt;
            r_svc_start <= w_svc_start_nxt;
        end
    end

    // Statistics: clear beats any same-cycle increment or flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_count  <= '0;
            r_protocol_err <= 1'b0;
            r_timeout      <= 1'b0;
        end else if (bus.clr_i) begin
            r_grant_count  <= '0;
            r_protocol_err <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            if (w_grant_inc && r_grant_count != '1) r_grant_count <= r_grant_count + 1'b1;
            if (w_err_set)                          r_protocol_err <= 1'b1;
            if (w_timeout_set)                      r_timeout      <= 1'b1;
        end
    end

    assign bus.ack_o          = r_ack;
    assign bus.busy_o         = r_busy;
    assign bus.svc_start_o    = r_svc_start;
    assign bus.grant_count_o  = r_grant_count;
    assign bus.protocol_err_o = r_protocol_err;
    assign bus.timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb_root_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_root_responder
// Description : Directed self-checking bench for arb_root_responder. One
//               default-width instance plus a CNT_W=2 instance for counter
//               saturation. Build with ARB_RESP_TIMEOUT_EN to exercise the
//               watchdog (TIMEOUT_CYCLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_root_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    arb_root_responder_if #(.CNT_W(16)) bus0 ();
    arb_root_responder_if #(.CNT_W(2))  bus1 ();

    arb_root_responder #(
        .SYNC_STAGES(2), .SERVICE_CYCLES(4), .CNT_W(16), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );

    arb_root_responder #(
        .SYNC_STAGES(2), .SERVICE_CYCLES(4), .CNT_W(2), .TIMEOUT_CYCLES(8)
    ) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int sel, input logic v);
        if (sel == 0) bus0.req_i = v;
        else          bus1.req_i = v;
    endtask

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? bus0.ack_o : bus1.ack_o;
    endfunction

    function automatic logic get_svc(input int sel);
        return (sel == 0) ? bus0.svc_start_o : bus1.svc_start_o;
    endfunction

    // Raise req until ack, return edges-to-ack; returns 0 on timeout
    task automatic raise_wait(input int sel, output int up, output int pulses);
        set_req(sel, 1'b1);
        up = 0;
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (get_svc(sel)) pulses++;
            if (get_ack(sel)) begin
                up = i;
                break;
            end
        end
    endtask

    // Drop req until ack falls, return edges-to-release; 0 on timeout
    task automatic drop_wait(input int sel, output int dn);
        set_req(sel, 1'b0);
        dn = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (!get_ack(sel)) begin
                dn = i;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        bus0.clr_i = 1'b1;
        tick();
        bus0.clr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int up, dn, pulses, tot, any_ack, any_svc, hi;

        bus0.req_i = 1'b0;
        bus0.clr_i = 1'b0;
        bus1.req_i = 1'b0;
        bus1.clr_i = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_ack",    32'(bus0.ack_o),          32'd0);
        chk("rst_busy",   32'(bus0.busy_o),         32'd0);
        chk("rst_svc",    32'(bus0.svc_start_o),    32'd0);
        chk("rst_cnt",    32'(bus0.grant_count_o),  32'd0);
        chk("rst_err",    32'(bus0.protocol_err_o), 32'd0);
        chk("rst_to",     32'(bus0.timeout_o),      32'd0);
        rst_n = 1'b1;
        tick();

        // Single handshake, edge-by-edge timing
        bus0.req_i = 1'b1;
        tick();                                   // E1
        tick();                                   // E2
        chk("t1_svc_e2",  32'(bus0.svc_start_o),   32'd0);
        tick();                                   // E3
        chk("t1_svc_e3",  32'(bus0.svc_start_o),   32'd1);
        chk("t1_busy_e3", 32'(bus0.busy_o),        32'd1);
        tick();                                   // E4
        chk("t1_svc_e4",  32'(bus0.svc_start_o),   32'd0);
        tick();                                   // E5
        tick();                                   // E6
        chk("t1_ack_e6",  32'(bus0.ack_o),         32'd0);
        tick();                                   // E7
        chk("t1_ack_e7",  32'(bus0.ack_o),         32'd1);
        chk("t1_cnt",     32'(bus0.grant_count_o), 32'd1);
        bus0.req_i = 1'b0;
        tick();                                   // F1
        tick();                                   // F2
        chk("t1_ack_f2",  32'(bus0.ack_o),         32'd1);
        tick();                                   // F3
        chk("t1_ack_f3",  32'(bus0.ack_o),         32'd0);
        chk("t1_busy_f3", 32'(bus0.busy_o),        32'd0);

        // Clear, then three back-to-back handshakes
        pulse_clr();
        chk("t2_clr_cnt", 32'(bus0.grant_count_o), 32'd0);
        tot = 0;
        for (int k = 0; k < 3; k++) begin
            raise_wait(0, up, pulses);
            chk("t2_up_lat", 32'(up), 32'd7);
            tot += pulses;
            drop_wait(0, dn);
            chk("t2_dn_lat", 32'(dn), 32'd3);
        end
        chk("t2_pulses", 32'(tot),                  32'd3);
        chk("t2_cnt",    32'(bus0.grant_count_o),   32'd3);
        chk("t2_err",    32'(bus0.protocol_err_o),  32'd0);

        // Request withdrawn during SERVE
        bus0.req_i = 1'b1;
        repeat (3) tick();
        chk("t3_svc",  32'(bus0.svc_start_o), 32'd1);
        tick();
        bus0.req_i = 1'b0;
        any_ack = 0;
        repeat (10) begin
            tick();
            if (bus0.ack_o) any_ack = 1;
        end
        chk("t3_no_ack", 32'(any_ack),               32'd0);
        chk("t3_err",    32'(bus0.protocol_err_o),   32'd1);
        chk("t3_busy",   32'(bus0.busy_o),           32'd0);
        chk("t3_cnt",    32'(bus0.grant_count_o),    32'd3);
        pulse_clr();
        chk("t3_clr_err", 32'(bus0.protocol_err_o),  32'd0);
        chk("t3_clr_cnt", 32'(bus0.grant_count_o),   32'd0);

        // Request held high past ACK
        raise_wait(0, up, pulses);
        chk("t4_up_lat", 32'(up), 32'd7);
`ifdef ARB_RESP_TIMEOUT_EN
        hi = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (!bus0.ack_o) begin
                hi = i;
                break;
            end
        end
        chk("t4_ack_hold", 32'(hi),             32'd8);
        chk("t4_timeout",  32'(bus0.timeout_o), 32'd1);
        chk("t4_busy",     32'(bus0.busy_o),    32'd0);
        any_ack = 0;
        any_svc = 0;
        repeat (20) begin
            tick();
            if (bus0.ack_o)       any_ack = 1;
            if (bus0.svc_start_o) any_svc = 1;
        end
        chk("t4_no_regrant", 32'(any_ack), 32'd0);
        chk("t4_no_svc",     32'(any_svc), 32'd0);
        bus0.req_i = 1'b0;
        repeat (5) tick();
        raise_wait(0, up, pulses);
        chk("t4_regrant_lat", 32'(up), 32'd7);
        drop_wait(0, dn);
        chk("t4_cnt",        32'(bus0.grant_count_o), 32'd2);
        pulse_clr();
        chk("t4_clr_to",     32'(bus0.timeout_o),     32'd0);
`else
        hi = 0;
        repeat (100) begin
            tick();
            if (bus0.ack_o) hi++;
        end
        chk("t4_ack_hold", 32'(hi),             32'd100);
        chk("t4_timeout",  32'(bus0.timeout_o), 32'd0);
        drop_wait(0, dn);
        chk("t4_dn_lat",   32'(dn),             32'd3);
        chk("t4_cnt",      32'(bus0.grant_count_o), 32'd1);
`endif

        // Saturating counter, CNT_W=2
        for (int k = 0; k < 5; k++) begin
            raise_wait(1, up, pulses);
            drop_wait(1, dn);
        end
        chk("t5_sat_lat", 32'(up),                  32'd7);
        chk("t5_sat_cnt", 32'(bus1.grant_count_o),  32'd3);

        // Async reset while ack is high, request kept high
        raise_wait(0, up, pulses);
        chk("t6_up_lat", 32'(up), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_ack_async", 32'(bus0.ack_o),         32'd0);
        chk("t6_cnt_rst",   32'(bus0.grant_count_o), 32'd0);
        #2;
        rst_n = 1'b1;
        up = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus0.ack_o) begin
                up = i;
                break;
            end
        end
        chk("t6_reserve_lat", 32'(up),                  32'd7);
        chk("t6_cnt",         32'(bus0.grant_count_o),  32'd1);
        drop_wait(0, dn);
        chk("t6_dn_lat",      32'(dn),                  32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
